// File: rtl/lvg_pkg.sv
// Shared encodings for the lvg sequencer: host ops, lvg instr codes, FSM states.
// Combinational helpers only; no latency, no flow control.
package lvg_pkg;

    localparam int TILE_WORDS = 16;

    typedef enum logic [2:0] {
        OP_LOADL       = 3'd0,
        OP_LOADR       = 3'd1,
        OP_LOADA       = 3'd2,
        OP_STORE       = 3'd3,
        OP_MUL         = 3'd4,
        OP_MUL_ADD     = 3'd5,
        OP_MUL_ACT     = 3'd6,
        OP_MUL_ADD_ACT = 3'd7
    } op_e;

    localparam logic [7:0] INSTR_NOP         = 8'd0;
    localparam logic [7:0] INSTR_LOADL       = 8'd1;
    localparam logic [7:0] INSTR_LOADR       = 8'd2;
    localparam logic [7:0] INSTR_LOADA       = 8'd3;
    localparam logic [7:0] INSTR_STORE       = 8'd4;
    localparam logic [7:0] INSTR_MUL         = 8'd5;
    localparam logic [7:0] INSTR_MUL_ADD     = 8'd6;
    localparam logic [7:0] INSTR_MUL_ACT     = 8'd7;
    localparam logic [7:0] INSTR_MUL_ADD_ACT = 8'd8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_ISSUE,
        ST_HOLD,
        ST_EXEC,
        ST_DRAIN,
        ST_SEND
    } state_e;

    // Instr codes are the op encoding offset by one, leaving 0 as NOP.
    function automatic logic [7:0] op2instr(input op_e op);
        return {5'd0, op} + 8'd1;
    endfunction

    function automatic logic is_load(input op_e op);
        return (op == OP_LOADL) || (op == OP_LOADR) || (op == OP_LOADA);
    endfunction

    function automatic logic is_act(input op_e op);
        return (op == OP_MUL_ACT) || (op == OP_MUL_ADD_ACT);
    endfunction

endpackage

// File: rtl/lvg_tile_buf.sv
// 16x32 register file with indexed write, whole-tile load, indexed read and flat view.
// Writes land on the next clk edge; reads are combinational; no backpressure.
module lvg_tile_buf
    import lvg_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         we_i,
    input  logic [3:0]   widx_i,
    input  logic [31:0]  wdat_i,
    input  logic         ld_i,
    input  logic [511:0] ld_dat_i,
    input  logic [3:0]   ridx_i,
    output logic [31:0]  rdat_o,
    output logic [511:0] flat_o
);

    // Packed so word k sits at bits [32k+:32], matching lvg's port packing.
    logic [TILE_WORDS-1:0][31:0] mem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
        end else if (ld_i) begin
            mem_q <= ld_dat_i;
        end else if (we_i) begin
            mem_q[widx_i] <= wdat_i;
        end
    end

    assign rdat_o = mem_q[ridx_i];
    assign flat_o = mem_q;

endmodule

// File: rtl/lvg_sequencer.sv
// Command front-end / result back-end for lvg: loads tiles, times instr, streams results.
// Load done 2 cycles after word 15, compute capture at accept+LAT+DRAIN; in/out stall on valid/ready.
module lvg_sequencer
    import lvg_pkg::*;
#(
    parameter int MUL_LAT = 16,
    parameter int ACT_LAT = 17,
    parameter int DRAIN   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_last,
    output logic [7:0]   lvg_instr,
    output logic [511:0] lvg_mat,
    input  logic [511:0] lvg_res,
    output logic         busy,
    output logic         done
);

    state_e      state_q;
    op_e         op_q;
    logic [3:0]  widx_q;
    logic [3:0]  ridx_q;
    logic [4:0]  cnt_q;
    logic [7:0]  instr_q;
    logic        done_q;

    logic        in_fire;
    logic        out_fire;
    logic        res_ld;
    logic [4:0]  lat_last;
    logic [31:0] stg_rdat_unused;
    logic [511:0] res_flat_unused;

    assign cmd_ready = (state_q == ST_IDLE);
    assign in_ready  = (state_q == ST_RECV);
    assign out_valid = (state_q == ST_SEND);
    assign busy      = (state_q != ST_IDLE);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_last  = (ridx_q == 4'd15);
    assign lvg_instr = instr_q;
    assign done      = done_q;

    assign lat_last = is_act(op_q) ? 5'(ACT_LAT - 1) : 5'(MUL_LAT - 1);
    assign res_ld   = (state_q == ST_DRAIN) && (cnt_q == 5'(DRAIN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOADL;
            widx_q  <= '0;
            ridx_q  <= '0;
            cnt_q   <= '0;
            instr_q <= INSTR_NOP;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    instr_q <= INSTR_NOP;
                    if (cmd_valid) begin
                        op_q <= op_e'(cmd_op);
                        if (is_load(op_e'(cmd_op))) begin
                            state_q <= ST_RECV;
                            widx_q  <= '0;
                        end else if (op_e'(cmd_op) == OP_STORE) begin
                            state_q <= ST_SEND;
                            ridx_q  <= '0;
                            instr_q <= INSTR_STORE;
                        end else begin
                            state_q <= ST_EXEC;
                            cnt_q   <= '0;
                            instr_q <= op2instr(op_e'(cmd_op));
                        end
                    end
                end
                ST_RECV: begin
                    if (in_fire) begin
                        if (widx_q == 4'd15) begin
                            state_q <= ST_ISSUE;
                            instr_q <= op2instr(op_q);
                        end else begin
                            widx_q <= widx_q + 4'd1;
                        end
                    end
                end
                ST_ISSUE: begin
                    instr_q <= INSTR_NOP;
                    state_q <= ST_HOLD;
                end
                // Staging stays untouched here so lvg's load strobe sees a stable tile.
                ST_HOLD: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b1;
                end
                ST_EXEC: begin
                    if (cnt_q == lat_last) begin
                        instr_q <= INSTR_NOP;
                        cnt_q   <= '0;
                        state_q <= ST_DRAIN;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                ST_DRAIN: begin
                    if (res_ld) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                ST_SEND: begin
                    instr_q <= INSTR_NOP;
                    if (out_fire) begin
                        if (ridx_q == 4'd15) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            ridx_q <= ridx_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    instr_q <= INSTR_NOP;
                end
            endcase
        end
    end

    lvg_tile_buf u_stage (
        .clk      (clk),
        .rst      (rst),
        .we_i     (in_fire),
        .widx_i   (widx_q),
        .wdat_i   (in_data),
        .ld_i     (1'b0),
        .ld_dat_i ('0),
        .ridx_i   (4'd0),
        .rdat_o   (stg_rdat_unused),
        .flat_o   (lvg_mat)
    );

    lvg_tile_buf u_result (
        .clk      (clk),
        .rst      (rst),
        .we_i     (1'b0),
        .widx_i   (4'd0),
        .wdat_i   (32'd0),
        .ld_i     (res_ld),
        .ld_dat_i (lvg_res),
        .ridx_i   (ridx_q),
        .rdat_o   (out_data),
        .flat_o   (res_flat_unused)
    );

endmodule

// File: tb/tb_lvg_sequencer.sv
// Directed bench for lvg_sequencer with a small behavioural lvg engine on lvg_instr/lvg_mat/lvg_res.
module tb_lvg_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic [7:0]   lvg_instr;
    logic [511:0] lvg_mat;
    logic [511:0] lvg_res = '0;
    logic         busy;
    logic         done;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] vec[16];
    logic [31:0] expv[16];

    always #5 clk = ~clk;

    lvg_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .lvg_instr (lvg_instr),
        .lvg_mat   (lvg_mat),
        .lvg_res   (lvg_res),
        .busy      (busy),
        .done      (done)
    );

    // Behavioural lvg: acts only when instr changes, like the real engine.
    logic [7:0]  m_prev = 8'd0;
    logic [31:0] m_l[16];
    logic [31:0] m_r[16];
    logic [31:0] m_a[16];

    function automatic logic [511:0] model_res(input logic [7:0] ins);
        logic [511:0] r;
        int acc;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = 0;
                for (int k = 0; k < 4; k++)
                    acc += $signed(m_l[i*4+k]) * $signed(m_r[k*4+j]);
                if (ins == 8'd6 || ins == 8'd8) acc += $signed(m_a[i*4+j]);
                if ((ins == 8'd7 || ins == 8'd8) && acc < 0) acc = 0;
                r[32*(i*4+j) +: 32] = acc;
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (lvg_instr != m_prev) begin
            for (int k = 0; k < 16; k++) begin
                if (lvg_instr == 8'd1) m_l[k] <= lvg_mat[32*k +: 32];
                if (lvg_instr == 8'd2) m_r[k] <= lvg_mat[32*k +: 32];
                if (lvg_instr == 8'd3) m_a[k] <= lvg_mat[32*k +: 32];
            end
            if (lvg_instr >= 8'd5 && lvg_instr <= 8'd8) lvg_res <= model_res(lvg_instr);
        end
        m_prev <= lvg_instr;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic [2:0] op);
        int n;
        n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        check_vec("cmd_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_load(input logic [2:0] op, input bit gapped);
        issue_cmd(op);
        for (int k = 0; k < 16; k++) begin
            if (gapped) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = vec[k];
            tick();
        end
        in_valid = 1'b0;
        check_vec("ld_issue", {24'd0, lvg_instr}, 32'(op) + 32'd1);
        check_vec("ld_done_early", {31'd0, done}, 32'd0);
        tick();
        check_vec("ld_nop", {24'd0, lvg_instr}, 32'd0);
        tick();
        check_vec("ld_done", {31'd0, done}, 32'd1);
    endtask

    task automatic do_compute(input logic [2:0] op, input int lat);
        int held;
        int idx;
        issue_cmd(op);
        held = 0;
        idx  = 0;
        while (!done && idx < 60) begin
            if (lvg_instr == 8'(op) + 8'd1) held++;
            tick();
            idx++;
        end
        check_vec("exec_hold", held, lat);
        check_vec("exec_done_cyc", idx, lat + 2);
        check_vec("exec_nop", {24'd0, lvg_instr}, 32'd0);
    endtask

    task automatic do_store(input bit toggle);
        int beats;
        int c;
        issue_cmd(3'd3);
        check_vec("st_instr", {24'd0, lvg_instr}, 32'd4);
        beats = 0;
        c     = 0;
        while (!done && c < 200) begin
            out_ready = toggle ? (c % 3 == 0) : 1'b1;
            if (out_valid) begin
                check_vec("st_data", out_data, expv[beats & 15]);
                check_vec("st_last", {31'd0, out_last}, (beats == 15) ? 32'd1 : 32'd0);
                if (out_ready) beats++;
            end
            tick();
            c++;
        end
        out_ready = 1'b0;
        check_vec("st_beats", beats, 16);
        check_vec("st_done", {31'd0, done}, 32'd1);
        check_vec("st_ovld", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int hist[60];
        int n5, n7, last5, first7;
        bit rdy;

        for (int k = 0; k < 16; k++) begin
            m_l[k] = '0;
            m_r[k] = '0;
            m_a[k] = '0;
        end
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        check_vec("rst_instr", {24'd0, lvg_instr}, 32'd0);
        check_vec("rst_busy", {31'd0, busy}, 32'd0);
        check_vec("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_vec("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_vec("rst_done", {31'd0, done}, 32'd0);

        // STORE before any compute yields zeros.
        for (int k = 0; k < 16; k++) expv[k] = 32'd0;
        do_store(1'b0);

        // Gapped LOADL of 1..16.
        for (int k = 0; k < 16; k++) vec[k] = 32'(k + 1);
        do_load(3'd0, 1'b1);
        check_vec("mat_w0", lvg_mat[31:0], 32'd1);
        check_vec("mat_w15", lvg_mat[511:480], 32'd16);

        // L = identity, R = 1..16, MUL -> result R.
        for (int k = 0; k < 16; k++) vec[k] = (k % 5 == 0) ? 32'd1 : 32'd0;
        do_load(3'd0, 1'b0);
        for (int k = 0; k < 16; k++) vec[k] = 32'(k + 1);
        do_load(3'd1, 1'b0);
        do_compute(3'd4, 16);
        for (int k = 0; k < 16; k++) expv[k] = 32'(k + 1);
        do_store(1'b0);
        do_store(1'b1);

        // R with negatives; MUL then MUL_ACT back to back with cmd_valid held.
        for (int k = 0; k < 16; k++) vec[k] = (k % 2 == 1) ? -32'(k + 1) : 32'(k + 1);
        do_load(3'd1, 1'b0);
        check_vec("b2b_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = 3'd4;
        tick();
        cmd_op = 3'd6;
        for (int i = 0; i < 60; i++) begin
            hist[i] = int'(lvg_instr);
            rdy = cmd_ready && cmd_valid;
            tick();
            if (rdy) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        n5 = 0; n7 = 0; last5 = -1; first7 = -1;
        for (int i = 0; i < 60; i++) begin
            if (hist[i] == 5) begin n5++; last5 = i; end
            if (hist[i] == 7) begin n7++; if (first7 < 0) first7 = i; end
        end
        check_vec("b2b_mul_hold", n5, 16);
        check_vec("b2b_act_hold", n7, 17);
        check_vec("b2b_nop_gap", first7 - last5 - 1, 3);
        for (int k = 0; k < 16; k++) expv[k] = (k % 2 == 1) ? 32'd0 : 32'(k + 1);
        do_store(1'b0);

        // Reset in the middle of EXEC at cnt=5.
        issue_cmd(3'd4);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check_vec("mid_rst_instr", {24'd0, lvg_instr}, 32'd0);
        check_vec("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_vec("mid_rst_stage", {31'd0, |lvg_mat}, 32'd0);
        rst = 1'b0;
        tick();
        for (int k = 0; k < 16; k++) expv[k] = 32'd0;
        do_store(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
